// File: rtl/fetch_ctrl_if.sv
// Instruction-memory fetch port shared by fetch_ctrl (master) and the instruction memory (slave).
// Handshake: a word moves when im_req && im_ready in the same cycle; im_rdata must then be the word at im_addr.
interface fetch_ctrl_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;

  modport master (output im_req, output im_addr, input im_ready, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_ready, output im_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// MIPS instruction-fetch sequencer: owns the PC, drives the IM fetch port and loads the IF/ID registers.
// FETCH_CTRL_DELAY_SLOT_EN selects delay-slot redirects; undefined, a redirect squashes the in-flight fetch.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              jmp,
  input  logic [31:0]       jmp_target,
  fetch_ctrl_if.master      im,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc4,
  output logic              if_valid,
  output logic              addr_err,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // One past the last legal byte address; 33 bits so the bound cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;
  logic        r_if_valid;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_if_instr_nxt;
  logic [31:0] w_if_pc_nxt;
  logic [31:0] w_if_pc4_nxt;
  logic        w_if_valid_nxt;

  logic        w_legal;
  logic        w_req;
  logic        w_xfer;
  logic        w_redir;
  logic [31:0] w_redir_tgt;
  logic [31:0] w_pc4;

`ifdef FETCH_CTRL_DELAY_SLOT_EN
  logic [31:0] r_pend_tgt;
  logic [31:0] w_pend_nxt;
`endif

  assign w_pc4       = r_pc + 32'd4;
  assign w_legal     = (r_pc[1:0] == 2'b00) && (r_pc >= IM_BASE) && ({1'b0, r_pc} < IM_LIMIT);
  assign w_req       = !reset && !stall && (r_state != ST_ERR) && w_legal;
  assign w_xfer      = w_req && im.im_ready;
  assign w_redir     = br_taken || jmp;
  assign w_redir_tgt = br_taken ? br_target : jmp_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_if_instr <= 32'd0;
      r_if_pc    <= 32'd0;
      r_if_pc4   <= 32'd0;
      r_if_valid <= 1'b0;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
      r_pend_tgt <= 32'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
      r_if_pc4   <= w_if_pc4_nxt;
      r_if_valid <= w_if_valid_nxt;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
      r_pend_tgt <= w_pend_nxt;
`endif
    end
  end

  // Stall freezes everything; otherwise IF/ID takes a bubble unless a word transfers.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    w_if_pc4_nxt   = r_if_pc4;
    w_if_valid_nxt = r_if_valid;
`ifdef FETCH_CTRL_DELAY_SLOT_EN
    w_pend_nxt     = r_pend_tgt;
`endif
    if (!stall) begin
      w_if_instr_nxt = 32'd0;
      w_if_pc_nxt    = 32'd0;
      w_if_pc4_nxt   = 32'd0;
      w_if_valid_nxt = 1'b0;
      if ((r_state == ST_ERR) || !w_legal) begin
        w_state_nxt = ST_ERR;
      end else begin
        if (w_xfer) begin
          w_if_instr_nxt = im.im_rdata;
          w_if_pc_nxt    = r_pc;
          w_if_pc4_nxt   = w_pc4;
          w_if_valid_nxt = 1'b1;
        end
`ifdef FETCH_CTRL_DELAY_SLOT_EN
        if (r_state == ST_PEND) begin
          // Redirects seen here are ignored: the delay slot is still in IF.
          if (w_xfer) begin
            w_pc_nxt    = r_pend_tgt;
            w_state_nxt = ST_RUN;
          end
        end else if (w_xfer) begin
          w_pc_nxt = w_redir ? w_redir_tgt : w_pc4;
        end else if (w_redir) begin
          w_pend_nxt  = w_redir_tgt;
          w_state_nxt = ST_PEND;
        end
`else
        if (w_redir) begin
          // Squash: drop whatever came back this cycle and refetch at the target.
          w_if_instr_nxt = 32'd0;
          w_if_pc_nxt    = 32'd0;
          w_if_pc4_nxt   = 32'd0;
          w_if_valid_nxt = 1'b0;
          w_pc_nxt       = w_redir_tgt;
        end else if (w_xfer) begin
          w_pc_nxt = w_pc4;
        end
`endif
      end
    end
  end

  always_comb begin
    im.im_req   = w_req;
    im.im_addr  = r_pc;
    addr_err    = (r_state == ST_ERR) || (!stall && !w_legal);
    o_dbg_state = r_state;
    if_instr    = r_if_instr;
    if_pc       = r_if_pc;
    if_pc4      = r_if_pc4;
    if_valid    = r_if_valid;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, steady fetch, stall, redirects, address faults.
// Expectations follow FETCH_CTRL_DELAY_SLOT_EN where the two redirect modes differ.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        addr_err;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .im          (bus),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .if_valid    (if_valid),
    .addr_err    (addr_err),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Instruction memory model: each word is a fixed pattern of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus.im_rdata = mem_word(bus.im_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    stall    = 1'b0;
    br_taken = 1'b0;
    jmp      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    stall        = 1'b0;
    br_taken     = 1'b0;
    br_target    = 32'd0;
    jmp          = 1'b0;
    jmp_target   = 32'd0;
    bus.im_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_pc4", if_pc4, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_im_addr", bus.im_addr, 32'h3000);
    chk("rst_im_req", 32'(bus.im_req), 32'd0);

    // Steady fetch
    reset = 1'b0;
    bus.im_ready = 1'b1;
    #1;
    chk("run_im_req", 32'(bus.im_req), 32'd1);
    chk("run_im_addr0", bus.im_addr, 32'h3000);
    tick();
    chk("run_if_pc0", if_pc, 32'h3000);
    chk("run_if_instr0", if_instr, mem_word(32'h3000));
    chk("run_if_pc4_0", if_pc4, 32'h3004);
    chk("run_if_valid0", 32'(if_valid), 32'd1);
    chk("run_im_addr1", bus.im_addr, 32'h3004);
    tick();
    chk("run_if_pc1", if_pc, 32'h3004);
    chk("run_if_pc4_1", if_pc4, 32'h3008);
    chk("run_im_addr2", bus.im_addr, 32'h3008);

    // Stall with a redirect present: everything holds, redirect ignored
    stall = 1'b1;
    br_taken = 1'b1;
    br_target = 32'h3500;
    #1;
    chk("stall_im_req", 32'(bus.im_req), 32'd0);
    tick();
    chk("stall_if_pc_a", if_pc, 32'h3004);
    chk("stall_im_addr_a", bus.im_addr, 32'h3008);
    tick();
    chk("stall_if_pc_b", if_pc, 32'h3004);
    chk("stall_if_valid_b", 32'(if_valid), 32'd1);
    chk("stall_im_addr_b", bus.im_addr, 32'h3008);
    stall = 1'b0;
    br_taken = 1'b0;
    #1;
    chk("unstall_im_req", 32'(bus.im_req), 32'd1);
    tick();
    chk("unstall_if_pc", if_pc, 32'h3008);
    chk("unstall_im_addr", bus.im_addr, 32'h300C);

    // Branch taken with memory ready
    br_taken = 1'b1;
    br_target = 32'h3100;
    tick();
`ifdef FETCH_CTRL_DELAY_SLOT_EN
    chk("br_slot_if_pc", if_pc, 32'h300C);
    chk("br_slot_if_valid", 32'(if_valid), 32'd1);
`else
    chk("br_squash_if_valid", 32'(if_valid), 32'd0);
    chk("br_squash_if_instr", if_instr, 32'd0);
`endif
    chk("br_im_addr", bus.im_addr, 32'h3100);
    br_taken = 1'b0;
    tick();
    chk("br_tgt_if_pc", if_pc, 32'h3100);
    chk("br_tgt_if_instr", if_instr, mem_word(32'h3100));
    chk("br_tgt_im_addr", bus.im_addr, 32'h3104);

    // Branch taken while memory is not ready
    do_reset();
    tick();
    tick();
    tick();
    chk("miss_pre_im_addr", bus.im_addr, 32'h300C);
    chk("miss_pre_if_pc", if_pc, 32'h3008);
    bus.im_ready = 1'b0;
    br_taken = 1'b1;
    br_target = 32'h3100;
    tick();
    chk("miss_b1_valid", 32'(if_valid), 32'd0);
    chk("miss_b1_instr", if_instr, 32'd0);
`ifdef FETCH_CTRL_DELAY_SLOT_EN
    chk("miss_b1_im_addr", bus.im_addr, 32'h300C);
`else
    chk("miss_b1_im_addr", bus.im_addr, 32'h3100);
`endif
    br_taken = 1'b0;
    tick();
    chk("miss_b2_valid", 32'(if_valid), 32'd0);
    chk("miss_b2_instr", if_instr, 32'd0);
    bus.im_ready = 1'b1;
    tick();
`ifdef FETCH_CTRL_DELAY_SLOT_EN
    chk("miss_slot_if_pc", if_pc, 32'h300C);
    chk("miss_slot_im_addr", bus.im_addr, 32'h3100);
    tick();
    chk("miss_tgt_if_pc", if_pc, 32'h3100);
`else
    chk("miss_tgt_if_pc", if_pc, 32'h3100);
    chk("miss_tgt_im_addr", bus.im_addr, 32'h3104);
    tick();
    chk("miss_next_if_pc", if_pc, 32'h3104);
`endif

    // Branch wins over a simultaneous jump
    br_taken = 1'b1;
    br_target = 32'h3200;
    jmp = 1'b1;
    jmp_target = 32'h3300;
    tick();
    br_taken = 1'b0;
    jmp = 1'b0;
    tick();
    chk("prio_if_pc", if_pc, 32'h3200);
    chk("prio_im_addr", bus.im_addr, 32'h3204);

    // Last legal word fetched, then running off the top faults
    jmp = 1'b1;
    jmp_target = 32'h6FFC;
    tick();
    jmp = 1'b0;
    tick();
    chk("top_if_pc", if_pc, 32'h6FFC);
    chk("top_if_valid", 32'(if_valid), 32'd1);
    chk("top_im_addr", bus.im_addr, 32'h7000);
    chk("top_im_req", 32'(bus.im_req), 32'd0);
    chk("top_addr_err", 32'(addr_err), 32'd1);
    tick();
    chk("err_if_valid_a", 32'(if_valid), 32'd0);
    chk("err_addr_err_a", 32'(addr_err), 32'd1);
    chk("err_state", 32'(dbg_state), 32'd2);
    tick();
    chk("err_if_valid_b", 32'(if_valid), 32'd0);
    chk("err_addr_err_b", 32'(addr_err), 32'd1);
    chk("err_im_req_b", 32'(bus.im_req), 32'd0);

    // Reset clears the fault
    do_reset();
    chk("rec_addr_err", 32'(addr_err), 32'd0);
    chk("rec_im_addr", bus.im_addr, 32'h3000);
    chk("rec_im_req", 32'(bus.im_req), 32'd1);
    chk("rec_if_valid", 32'(if_valid), 32'd0);

    // Jump below the IM base
    jmp = 1'b1;
    jmp_target = 32'h2FFC;
    tick();
    jmp = 1'b0;
    #1;
    chk("low_im_addr", bus.im_addr, 32'h2FFC);
    chk("low_addr_err", 32'(addr_err), 32'd1);
    chk("low_im_req", 32'(bus.im_req), 32'd0);
    tick();
    chk("low_if_valid", 32'(if_valid), 32'd0);
    chk("low_addr_err_hold", 32'(addr_err), 32'd1);
    do_reset();
    chk("low_rec_addr_err", 32'(addr_err), 32'd0);
    chk("low_rec_im_addr", bus.im_addr, 32'h3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the pipelined MIPS core. It owns the PC register and presents fetch addresses to the instruction memory over a req/ready handshake. It delivers fetched words into the IF/ID boundary registers and applies stall, branch and jump redirects with MIPS delay-slot semantics. It sits between the hazard unit and D-stage branch/jump resolution on one side and the instruction memory on the other, and replaces the PC logic embedded in the memory.

Parameters:
RESET_PC, 32'h00003000, PC value after reset
IM_BASE, 32'h00003000, lowest legal fetch byte address
IM_WORDS, 4096, instruction memory depth in words; legal range is IM_BASE .. IM_BASE+4*IM_WORDS-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  hazard-unit stall; holds PC and IF/ID
br_taken  in  1  D-stage branch resolved taken
br_target  in  32  branch target byte address
jmp  in  1  D-stage j/jal/jr
jmp_target  in  32  jump target byte address
im_req  out  1  fetch request
im_addr  out  32  fetch byte address (equals current PC)
im_ready  in  1  im_rdata valid for im_addr this cycle
im_rdata  in  32  fetched instruction
if_instr  out  32  IF/ID instruction (0 = nop on bubble)
if_pc  out  32  IF/ID instruction address
if_pc4  out  32  IF/ID address + 4
if_valid  out  1  IF/ID holds a real instruction
addr_err  out  1  sticky fetch-address fault

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. All state changes on posedge clk.
- Reset values: pc=RESET_PC; state=RUN; pending redirect cleared; if_instr=0, if_pc=0, if_pc4=0, if_valid=0, addr_err=0. The first request is issued in the cycle after reset deasserts. Reset overrides all other inputs in every state, including mid-miss and ERR.
- Combinational outputs:
  - im_addr = pc.
  - im_req = !stall && state!=ERR && pc legal.
  - Transfer occurs when im_req && im_ready.
- pc legality: pc[1:0]==0 and IM_BASE <= pc < IM_BASE+4*IM_WORDS.
- Redirect:
  - Sampled only when stall=0; ignored while stall=1, because the D-stage instruction is not final.
  - Priority: br_taken over jmp. Target is br_target, else jmp_target.
- FSM states:
  - RUN: no redirect pending.
    - Transfer: IF/ID <= {im_rdata, pc, pc+4, valid=1}. pc <= redirect target if a redirect is present, else pc+4.
    - No transfer and stall=0: IF/ID <= bubble {0, 0, 0, valid=0}; pc holds. A redirect seen this cycle is stored as pending; go to PEND.
  - PEND: a redirect is pending and the delay slot has not yet been fetched.
    - Transfer: IF/ID <= delay slot; pc <= pending target; go to RUN.
    - No transfer: bubble; stay in PEND.
    - New redirects are ignored in PEND. A second control instruction cannot be in D before the delay slot leaves IF.
  - ERR: entered from any state when stall=0 and pc is illegal. addr_err=1; im_req=0; IF/ID receives bubbles; state holds until reset.
- stall=1 (any state): pc, state, pending target and IF/ID all hold. im_req=0.
- Latency: im_ready held at 1 gives one instruction per cycle. Instruction at address A appears on if_* in the cycle after its transfer.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32; a wrapped address is then illegal and raises ERR.

Optional Feature:
Macro FETCH_CTRL_DELAY_SLOT_EN.
- Defined: delay-slot semantics exactly as in Behaviour, including the PEND state.
- Undefined: a redirect squashes the in-flight fetch.
  - In the redirect cycle (stall=0), IF/ID <= bubble regardless of im_ready, and pc <= target.
  - The PEND state does not exist. im_rdata from that cycle is discarded.

Test Plan:
- Reset 2 cycles, then im_ready=1 and im_rdata=word at im_addr -> im_addr 3000, 3004, 3008; if_pc 3000, 3004 one cycle later; if_valid=1 from the first post-reset edge; if_pc4=if_pc+4.
- Steady fetch, stall=1 for 2 cycles at pc=0x3008 -> im_req=0, im_addr stays 0x3008, if_* unchanged; fetch resumes at 0x3008.
- br_taken=1 with br_target=0x3100 while im_addr=0x300C, im_ready=1 -> if_pc 0x300C (delay slot), then 0x3100; 0x3010 is never fetched.
- br_taken=1 with target 0x3100 while im_addr=0x300C and im_ready=0 for 2 cycles -> 2 bubbles (if_valid=0, if_instr=0), then if_pc 0x300C, then 0x3100.
- jmp=1 with jmp_target=0x2FFC -> next cycle addr_err=1, im_req=0, if_valid=0 persists; reset -> addr_err=0, im_addr=0x3000.
- Macro undefined, scenario 3 -> bubble in the redirect cycle; next if_pc=0x3100; 0x300C is never delivered.
